// File: rtl/alu_seq_pkg.sv
// Shared definitions for the register-register ALU sequencer: state encoding,
// legal opcode range and IR field positions.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5
   } seq_state_e;

   localparam int unsigned OP_ADD  = 3;
   localparam int unsigned OP_SUB  = 4;
   localparam int unsigned OP_AND  = 5;
   localparam int unsigned OP_OR   = 6;
   localparam int unsigned OP_ROR  = 7;
   localparam int unsigned OP_ROL  = 8;
   localparam int unsigned OP_SHR  = 9;
   localparam int unsigned OP_SHRA = 10;
   localparam int unsigned OP_SHL  = 11;

   // MSB position of each IR field; fields extend downward by their width
   localparam int OPCODE_MSB = 31;
   localparam int RA_MSB     = 26;
   localparam int RB_MSB     = 22;
   localparam int RC_MSB     = 18;

   function automatic logic opcode_legal(input int unsigned op);
      return (op >= OP_ADD) && (op <= OP_SHL);
   endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot enable decoder; flags indices beyond NUM_REGS.
module reg_onehot_dec #(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = 4
) (
   input  logic [REG_SEL_W-1:0] idx,
   input  logic                 en,
   output logic [NUM_REGS-1:0]  onehot,
   output logic                 oor
);

   assign oor = (32'(idx) >= 32'(NUM_REGS));

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && !oor && (32'(idx) == 32'(i)))
            onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Control sequencer for register-register ALU instructions (fetch T0-T2, execute T3-T5).
// Optional memory wait states in T1 are enabled by defining ALU_SEQ_MEM_WAIT_EN.
module alu_rr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = 4,
   parameter int OPCODE_W  = 5
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                start,
   input  logic                mem_rdy,
   input  logic [31:0]         ir,
   output logic                pc_out,
   output logic                mar_in,
   output logic                inc_pc,
   output logic                pc_in,
   output logic                z_in,
   output logic                zlow_out,
   output logic                read,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                ir_in,
   output logic                y_in,
   output logic [NUM_REGS-1:0] reg_out,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [OPCODE_W-1:0] alu_op,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   seq_state_e state, state_nxt;

   logic [OPCODE_W-1:0]  opcode;
   logic [REG_SEL_W-1:0] ra, rb, rc, ro_idx;
   logic                 ro_en, ri_en;
   logic                 ro_oor, ra_oor, rc_oor;
   logic                 legal, t1_last;

   assign opcode = ir[OPCODE_MSB -: OPCODE_W];
   assign ra     = ir[RA_MSB -: REG_SEL_W];
   assign rb     = ir[RB_MSB -: REG_SEL_W];
   assign rc     = ir[RC_MSB -: REG_SEL_W];

`ifdef ALU_SEQ_MEM_WAIT_EN
   assign t1_last = mem_rdy;
   logic unused_ir;
   assign unused_ir = ^ir[RC_MSB-REG_SEL_W:0];
`else
   assign t1_last = 1'b1;
   logic unused_in;
   assign unused_in = ^{mem_rdy, ir[RC_MSB-REG_SEL_W:0]};
`endif

   // Rb drives the bus in T3, Rc in T4; one decoder serves both
   assign ro_idx = (state == S_T4) ? rc : rb;
   assign rc_oor = (32'(rc) >= 32'(NUM_REGS));
   // Only evaluated in T3, where the shared decoder is looking at Rb
   assign legal  = opcode_legal(32'(opcode)) && !ro_oor && !ra_oor && !rc_oor;

   reg_onehot_dec #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_dec_out (
      .idx    (ro_idx),
      .en     (ro_en),
      .onehot (reg_out),
      .oor    (ro_oor)
   );

   reg_onehot_dec #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_dec_in (
      .idx    (ra),
      .en     (ri_en),
      .onehot (reg_in),
      .oor    (ra_oor)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (start) state_nxt = S_T0;
         S_T0:   state_nxt = S_T1;
         S_T1:   state_nxt = t1_last ? S_T2 : S_T1;
         S_T2:   state_nxt = S_T3;
         S_T3:   state_nxt = legal ? S_T4 : S_IDLE;
         S_T4:   state_nxt = S_T5;
         S_T5:   state_nxt = start ? S_T0 : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pc_out   = 1'b0;
      mar_in   = 1'b0;
      inc_pc   = 1'b0;
      pc_in    = 1'b0;
      z_in     = 1'b0;
      zlow_out = 1'b0;
      read     = 1'b0;
      mdr_in   = 1'b0;
      mdr_out  = 1'b0;
      ir_in    = 1'b0;
      y_in     = 1'b0;
      ro_en    = 1'b0;
      ri_en    = 1'b0;
      alu_op   = '0;
      done     = 1'b0;
      illegal  = 1'b0;
      busy     = (state != S_IDLE);
      unique case (state)
         S_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         S_T1: begin
            read     = 1'b1;
            mdr_in   = 1'b1;
            // PC reload only on the cycle that leaves T1, so it advances once
            zlow_out = t1_last;
            pc_in    = t1_last;
         end
         S_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         S_T3: begin
            if (legal) begin
               ro_en = 1'b1;
               y_in  = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         S_T4: begin
            ro_en  = 1'b1;
            alu_op = opcode;
            z_in   = 1'b1;
         end
         S_T5: begin
            zlow_out = 1'b1;
            ri_en    = 1'b1;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer: queue-based instruction model plus directed checks.
module tb_alu_rr_sequencer;

   localparam logic [10:0] B_PCOUT  = 11'h400;
   localparam logic [10:0] B_MARIN  = 11'h200;
   localparam logic [10:0] B_INCPC  = 11'h100;
   localparam logic [10:0] B_PCIN   = 11'h080;
   localparam logic [10:0] B_ZIN    = 11'h040;
   localparam logic [10:0] B_ZLOW   = 11'h020;
   localparam logic [10:0] B_READ   = 11'h010;
   localparam logic [10:0] B_MDRIN  = 11'h008;
   localparam logic [10:0] B_MDROUT = 11'h004;
   localparam logic [10:0] B_IRIN   = 11'h002;
   localparam logic [10:0] B_YIN    = 11'h001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr, start, mem_rdy;
   logic [31:0] ir;
   logic        pc_out, mar_in, inc_pc, pc_in, z_in, zlow_out, read, mdr_in, mdr_out, ir_in, y_in;
   logic [15:0] reg_out, reg_in;
   logic [4:0]  alu_op;
   logic        busy, done, illegal;

   logic        start8;
   logic [31:0] ir8;
   logic        pc_out8, mar_in8, inc_pc8, pc_in8, z_in8, zlow_out8, read8, mdr_in8, mdr_out8, ir_in8, y_in8;
   logic [7:0]  reg_out8, reg_in8;
   logic [4:0]  alu_op8;
   logic        busy8, done8, illegal8;

   alu_rr_sequencer #(.NUM_REGS(16), .REG_SEL_W(4), .OPCODE_W(5)) dut (
      .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir(ir),
      .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in), .z_in(z_in),
      .zlow_out(zlow_out), .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
      .y_in(y_in), .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op),
      .busy(busy), .done(done), .illegal(illegal)
   );

   alu_rr_sequencer #(.NUM_REGS(8), .REG_SEL_W(4), .OPCODE_W(5)) dut8 (
      .clk(clk), .clr(clr), .start(start8), .mem_rdy(mem_rdy), .ir(ir8),
      .pc_out(pc_out8), .mar_in(mar_in8), .inc_pc(inc_pc8), .pc_in(pc_in8), .z_in(z_in8),
      .zlow_out(zlow_out8), .read(read8), .mdr_in(mdr_in8), .mdr_out(mdr_out8), .ir_in(ir_in8),
      .y_in(y_in8), .reg_out(reg_out8), .reg_in(reg_in8), .alu_op(alu_op8),
      .busy(busy8), .done(done8), .illegal(illegal8)
   );

   logic [50:0] act_vec;
   assign act_vec = {pc_out, mar_in, inc_pc, pc_in, z_in, zlow_out, read, mdr_in, mdr_out,
                     ir_in, y_in, reg_out, reg_in, alu_op, busy, done, illegal};

   logic rdy_eff;
`ifdef ALU_SEQ_MEM_WAIT_EN
   assign rdy_eff = mem_rdy;
`else
   assign rdy_eff = 1'b1;
`endif

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: each accepted instruction becomes a list of per-cycle bus actions
   typedef struct packed {
      logic [10:0] strb;
      logic [15:0] ro;
      logic [15:0] ri;
      logic [4:0]  op;
      logic        dn;
      logic        il;
      logic        is_read;
   } step_t;

   step_t q[$];

   function automatic step_t mk(input logic [10:0] s, input logic [15:0] ro, input logic [15:0] ri,
                                input logic [4:0] op, input logic dn, input logic il, input logic rd);
      step_t t;
      t.strb = s; t.ro = ro; t.ri = ri; t.op = op; t.dn = dn; t.il = il; t.is_read = rd;
      return t;
   endfunction

   task automatic push_instr(input logic [31:0] w);
      int op, ra, rb, rc;
      op = int'(w[31:27]);
      ra = int'(w[26:23]);
      rb = int'(w[22:19]);
      rc = int'(w[18:15]);
      q.push_back(mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, '0, '0, '0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(B_READ | B_MDRIN, '0, '0, '0, 1'b0, 1'b0, 1'b1));
      q.push_back(mk(B_MDROUT | B_IRIN, '0, '0, '0, 1'b0, 1'b0, 1'b0));
      if (op >= 3 && op <= 11 && ra < 16 && rb < 16 && rc < 16) begin
         q.push_back(mk(B_YIN, 16'(1) << rb, '0, '0, 1'b0, 1'b0, 1'b0));
         q.push_back(mk(B_ZIN, 16'(1) << rc, '0, 5'(op), 1'b0, 1'b0, 1'b0));
         q.push_back(mk(B_ZLOW, '0, 16'(1) << ra, '0, 1'b1, 1'b0, 1'b0));
      end else begin
         q.push_back(mk('0, '0, '0, '0, 1'b0, 1'b1, 1'b0));
      end
   endtask

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         q.delete();
      end else begin
         logic accept;
         accept = 1'b0;
         if (q.size() == 0) begin
            accept = start;
         end else if (!(q[0].is_read && !rdy_eff)) begin
            if (q[0].dn && start) accept = 1'b1;
            void'(q.pop_front());
         end
         if (accept) push_instr(ir);
      end
   end

   always @(negedge clk) begin
      step_t       c;
      logic [10:0] s;
      logic [50:0] e;
      e = '0;
      if (q.size() != 0) begin
         c = q[0];
         s = c.strb;
         if (c.is_read && rdy_eff) s = s | B_ZLOW | B_PCIN;
         e = {s, c.ro, c.ri, c.op, 1'b1, c.dn, c.il};
      end
      chk("model_cycle", 64'(act_vec), 64'(e));
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc, ill_at, d1, d2, rd_cnt, pcin_cnt, dn_at;
      logic [15:0] ri_seen;
      logic [7:0]  ri8_seen;

      clr = 1'b1; start = 1'b0; start8 = 1'b0; ir = '0; ir8 = '0; mem_rdy = 1'b1;
      tick; tick;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_outputs", 64'(act_vec), 64'd0);
      chk("reset_busy8", 64'(busy8), 64'd0);
      clr = 1'b0;
      tick;

      // OR R1, R2, R3
      ir = 32'h30918000; start = 1'b1;
      tick; start = 1'b0;
      bc = 0;
      for (int k = 0; k < 8; k++) begin
         if (busy) bc++;
         if (k == 3) begin
            chk("or_t3_reg_out", 64'(reg_out), 64'h0004);
            chk("or_t3_y_in", 64'(y_in), 64'd1);
         end
         if (k == 4) begin
            chk("or_t4_reg_out", 64'(reg_out), 64'h0008);
            chk("or_t4_alu_op", 64'(alu_op), 64'd6);
            chk("or_t4_z_in", 64'(z_in), 64'd1);
         end
         if (k == 5) begin
            chk("or_t5_reg_in", 64'(reg_in), 64'h0002);
            chk("or_t5_done", 64'(done), 64'd1);
         end
         tick;
      end
      chk("or_busy_cycles", 64'(bc), 64'd6);

      // Opcode 0: illegal
      ir = 32'h00000000; start = 1'b1;
      tick; start = 1'b0;
      bc = 0; ill_at = -1; ri_seen = '0;
      for (int k = 0; k < 8; k++) begin
         if (busy) bc++;
         if (illegal) ill_at = k;
         ri_seen |= reg_in;
         tick;
      end
      chk("ill_busy_cycles", 64'(bc), 64'd4);
      chk("ill_pulse_t3", 64'(ill_at), 64'd3);
      chk("ill_no_reg_in", 64'(ri_seen), 64'd0);

      // Back-to-back with start held
      ir = 32'h30918000; start = 1'b1;
      tick;
      d1 = -1; d2 = -1;
      for (int k = 0; k < 14; k++) begin
         if (done) begin
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         if (k == 6) begin
            chk("b2b_second_t0", 64'({busy, pc_out}), 64'd3);
            start = 1'b0;
         end
         tick;
      end
      chk("b2b_first_done", 64'(d1), 64'd5);
      chk("b2b_done_gap", 64'(d2 - d1), 64'd6);
      chk("b2b_idle_after", 64'(busy), 64'd0);

      // Asynchronous clr in the middle of T4
      ir = 32'h30918000; start = 1'b1;
      tick; start = 1'b0;
      tick; tick; tick; tick;
      chk("pre_clr_t4_alu_op", 64'(alu_op), 64'd6);
      #1 clr = 1'b1;
      #1 chk("clr_async_outputs", 64'(act_vec), 64'd0);
      clr = 1'b0;
      tick;
      chk("post_clr_busy", 64'(busy), 64'd0);
      tick;
      chk("post_clr_outputs", 64'(act_vec), 64'd0);

`ifdef ALU_SEQ_MEM_WAIT_EN
      // Three wait cycles in T1
      ir = 32'h30918000; start = 1'b1;
      tick; start = 1'b0;
      rd_cnt = 0; pcin_cnt = 0; dn_at = -1;
      for (int k = 0; k < 12; k++) begin
         if (k >= 1) mem_rdy = (k < 4) ? 1'b0 : 1'b1;
         #1;
         if (read) rd_cnt++;
         if (pc_in) pcin_cnt++;
         if (done) dn_at = k;
         tick;
      end
      chk("wait_read_cycles", 64'(rd_cnt), 64'd4);
      chk("wait_pc_in_once", 64'(pcin_cnt), 64'd1);
      chk("wait_done_cycle", 64'(dn_at + 1), 64'd9);
      mem_rdy = 1'b1;
`else
      rd_cnt = 0; pcin_cnt = 0; dn_at = -1;
`endif

      // NUM_REGS = 8 with Ra = 9
      ir8 = 32'h34918000; start8 = 1'b1;
      tick; start8 = 1'b0;
      bc = 0; ill_at = -1; ri8_seen = '0;
      for (int k = 0; k < 8; k++) begin
         if (busy8) bc++;
         if (illegal8) ill_at = k;
         ri8_seen |= reg_in8;
         tick;
      end
      chk("n8_busy_cycles", 64'(bc), 64'd4);
      chk("n8_illegal_t3", 64'(ill_at), 64'd3);
      chk("n8_no_reg_in", 64'(ri8_seen), 64'd0);

      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
